// File: rtl/writeback_sequencer.sv
// writeback_sequencer: selects the result and drives the register-file write port, serialising link writes over two cycles
module writeback_sequencer #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int LINK_REG = 14,
  parameter int PC_REG   = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_is_load,
  input  logic              in_byte,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_link,
  input  logic [DATA_W-1:0] in_link_val,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic [CNT_W-1:0]  retired_count
);
  typedef enum logic {S_IDLE, S_LINK2} state_t;
  state_t state;
  logic pend_we, accept, nx_we, nx_pc;
  logic [REG_AW-1:0] pend_dest, nx_dest;
  logic [DATA_W-1:0] pend_data, res, nx_data;
  assign in_ready = state == S_IDLE;
  assign accept = in_valid && in_ready;
  assign res = in_is_load ? (in_byte ? {{(DATA_W-8){1'b0}}, in_mem_data[7:0]} : in_mem_data) : in_alu_result;
  // Next write-port values; the pending half of a linked pair always wins in S_LINK2
  always_comb begin
    nx_we = (state == S_LINK2) ? pend_we : accept && (in_link || in_we);
    nx_dest = (state == S_LINK2) ? pend_dest : !accept ? rf_dest : in_link ? REG_AW'(LINK_REG) : in_dest;
    nx_data = (state == S_LINK2) ? pend_data : !accept ? rf_data : in_link ? in_link_val : res;
    nx_pc = nx_we && nx_dest == REG_AW'(PC_REG);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pend_we <= 1'b0;
      pend_dest <= '0;
      pend_data <= '0;
      rf_we <= 1'b0;
      rf_dest <= '0;
      rf_data <= '0;
      pc_redirect <= 1'b0;
      pc_target <= '0;
      retired_count <= '0;
    end else begin
      rf_we <= nx_we;
      rf_dest <= nx_dest;
      rf_data <= nx_data;
      pc_redirect <= nx_pc;
      if (nx_pc) pc_target <= nx_data;
      if (accept) retired_count <= retired_count + CNT_W'(1);
      state <= (state == S_IDLE && accept && in_link) ? S_LINK2 : S_IDLE;
      if (accept && in_link) begin
        pend_we <= in_we;
        pend_dest <= in_dest;
        pend_data <= res;
      end
    end
  end
endmodule

// File: tb/tb_writeback_sequencer.sv
// tb_writeback_sequencer: directed scoreboard bench for writeback_sequencer (32-bit and 4-bit counter instances)
module tb_writeback_sequencer;
  logic clk = 0, reset = 1, in_valid = 0, in_we = 0, in_is_load = 0, in_byte = 0, in_link = 0;
  logic [3:0] in_dest = 0;
  logic [31:0] in_alu_result = 0, in_mem_data = 0, in_link_val = 0;
  logic in_ready, rf_we, pc_redirect, r4_ready, r4_we, r4_redirect;
  logic [3:0] rf_dest, r4_dest, r4_count;
  logic [31:0] rf_data, pc_target, retired_count, r4_data, r4_target;
  typedef struct {logic we; logic [3:0] dest; logic [31:0] data;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, w;
  logic [31:0] exp_cnt = 0;
  always #5 clk = ~clk;
  writeback_sequencer dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_dest(in_dest), .in_alu_result(in_alu_result), .in_is_load(in_is_load),
    .in_byte(in_byte), .in_mem_data(in_mem_data), .in_link(in_link), .in_link_val(in_link_val),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .retired_count(retired_count));
  writeback_sequencer #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r4_ready),
    .in_we(in_we), .in_dest(in_dest), .in_alu_result(in_alu_result), .in_is_load(in_is_load),
    .in_byte(in_byte), .in_mem_data(in_mem_data), .in_link(in_link), .in_link_val(in_link_val),
    .rf_we(r4_we), .rf_dest(r4_dest), .rf_data(r4_data), .pc_redirect(r4_redirect),
    .pc_target(r4_target), .retired_count(r4_count));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(string tag);
    exp_t e;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".we"}, 32'(rf_we), 32'(e.we));
      if (e.we) begin
        chk({tag, ".dest"}, 32'(rf_dest), 32'(e.dest));
        chk({tag, ".data"}, rf_data, e.data);
      end
      chk({tag, ".redir"}, 32'(pc_redirect), 32'(e.we && e.dest == 4'd15));
      if (e.we && e.dest == 4'd15) chk({tag, ".target"}, pc_target, e.data);
    end else begin
      chk({tag, ".idle_we"}, 32'(rf_we), 0);
      chk({tag, ".idle_redir"}, 32'(pc_redirect), 0);
    end
    chk({tag, ".count"}, retired_count, exp_cnt);
    chk({tag, ".count4"}, 32'(r4_count), 32'(exp_cnt[3:0]));
    chk({tag, ".we4"}, 32'(r4_we), 32'(rf_we));
  endtask
  task automatic send(string tag, logic link, logic we, logic [3:0] dest, logic [31:0] alu,
                      logic ld, logic byt, logic [31:0] mem, logic [31:0] lval, output int waits);
    logic [31:0] res;
    in_valid = 1; in_link = link; in_we = we; in_dest = dest; in_alu_result = alu;
    in_is_load = ld; in_byte = byt; in_mem_data = mem; in_link_val = lval;
    waits = 0;
    while (!in_ready && waits < 8) begin
      cyc({tag, ".stall"});
      waits++;
    end
    chk({tag, ".bound"}, 32'(waits < 8), 1);
    res = ld ? (byt ? {24'h0, mem[7:0]} : mem) : alu;
    if (link) q.push_back('{1'b1, 4'd14, lval});
    q.push_back('{we, dest, res});
    exp_cnt++;
    cyc(tag);
  endtask
  task automatic idle(string tag, int n);
    in_valid = 0;
    repeat (n) cyc(tag);
  endtask
  task automatic do_reset(string tag);
    reset = 1; in_valid = 0;
    @(posedge clk); #1;
    q.delete();
    exp_cnt = 0;
    chk({tag, ".we"}, 32'(rf_we), 0);
    chk({tag, ".dest"}, 32'(rf_dest), 0);
    chk({tag, ".data"}, rf_data, 0);
    chk({tag, ".redir"}, 32'(pc_redirect), 0);
    chk({tag, ".target"}, pc_target, 0);
    chk({tag, ".count"}, retired_count, 0);
    chk({tag, ".ready"}, 32'(in_ready), 1);
    reset = 0;
  endtask
  initial begin
    @(posedge clk); #1;
    do_reset("reset");
    send("alu", 0, 1, 4'd3, 32'hAAAAAAAA, 0, 0, 0, 0, w);
    idle("gap", 1);
    send("ldb", 0, 1, 4'd5, 32'h0, 1, 1, 32'h12345687, 0, w);
    send("ldw", 0, 1, 4'd6, 32'h0, 1, 0, 32'hCCCCCCCC, 0, w);
    send("nobyte", 0, 1, 4'd7, 32'h55, 0, 1, 32'h12345687, 0, w);
    send("nowe", 0, 0, 4'd8, 32'h99, 0, 0, 0, 0, w);
    idle("gap", 1);
    send("bl", 1, 1, 4'd15, 32'h200, 0, 0, 0, 32'h104, w);
    chk("bl.ready_lo", 32'(in_ready), 0);
    idle("bl2", 1);
    chk("bl.ready_hi", 32'(in_ready), 1);
    for (int i = 1; i <= 4; i++) begin
      send("b2b", 0, 1, 4'(i), 32'h1000 + i, 0, 0, 0, 0, w);
      chk("b2b.waits", w, 0);
    end
    send("lnk", 1, 1, 4'd2, 32'h22, 0, 0, 0, 32'h50, w);
    send("held", 0, 1, 4'd7, 32'h77, 0, 0, 0, 0, w);
    chk("held.waits", w, 1);
    send("lnk14", 1, 1, 4'd14, 32'h400, 0, 0, 0, 32'h300, w);
    idle("lnk14b", 1);
    chk("lnk14.final", rf_data, 32'h400);
    idle("gap", 1);
    send("lnkrst", 1, 1, 4'd9, 32'h9, 0, 0, 0, 32'h60, w);
    do_reset("midrst");
    cyc("postrst");
    for (int i = 0; i < 16; i++) send("wrap", 0, 1, 4'(i), 32'(i * 3), 0, 0, 0, 0, w);
    chk("wrap.count4", 32'(r4_count), 0);
    chk("wrap.count32", retired_count, 16);
    idle("end", 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
